// File: rtl/envelope_vca_if.sv
// Stream and envelope-control signals of envelope_vca, grouped for port connection.
// slave is the DUT view; master is the driver/consumer view.
interface envelope_vca_if #(
  parameter int unsigned SW = 16,
  parameter int unsigned EW = 18
);
  logic signed [SW-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic        [EW-1:0] env_value;
  logic                 env_busy;
  logic signed [SW-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 clamp_flag;
  logic                 clr_flag;

  modport master (
    output s_data, s_valid, env_value, env_busy, m_ready, clr_flag,
    input  s_ready, m_data, m_valid, clamp_flag
  );

  modport slave (
    input  s_data, s_valid, env_value, env_busy, m_ready, clr_flag,
    output s_ready, m_data, m_valid, clamp_flag
  );
endinterface

// File: rtl/envelope_vca.sv
// Two-stage VCA: scales signed samples by an envelope-derived 7-bit gain (unity = 128).
// Optional macro ENVELOPE_VCA_SMOOTH_EN slews the applied gain by at most 1 per accept.
module envelope_vca #(
  parameter int unsigned SW   = 16,
  parameter int unsigned EW   = 18,
  parameter int unsigned GMAX = 127
) (
  input  logic          clk,
  input  logic          rst_b,
  envelope_vca_if.slave bus
);

  logic                 advance;
  logic                 accept;
  logic                 over_gmax;
  logic [7:0]           target_gain;
  logic [7:0]           applied_gain;

  logic                 s1_valid_q, s1_valid_d;
  logic signed [SW-1:0] s1_data_q, s1_data_d;
  logic [7:0]           s1_gain_q, s1_gain_d;
  logic                 s2_valid_q, s2_valid_d;
  logic signed [SW-1:0] s2_data_q, s2_data_d;
  logic                 clamp_q, clamp_d;

  logic signed [SW+8:0] product;
  logic signed [SW-1:0] scaled;

  assign advance   = !s2_valid_q || bus.m_ready;
  assign accept    = bus.s_valid && advance;
  assign over_gmax = bus.env_value > EW'(GMAX);

  always_comb begin
    target_gain = 8'd0;
    if (bus.env_busy) begin
      target_gain = over_gmax ? 8'(GMAX) : bus.env_value[7:0];
    end
  end

`ifdef ENVELOPE_VCA_SMOOTH_EN
  logic [7:0] gain_q, gain_d;

  always_comb begin
    applied_gain = gain_q;
    if (target_gain > gain_q) begin
      applied_gain = gain_q + 8'd1;
    end else if (target_gain < gain_q) begin
      applied_gain = gain_q - 8'd1;
    end
    gain_d = accept ? applied_gain : gain_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      gain_q <= 8'd0;
    end else begin
      gain_q <= gain_d;
    end
  end
`else
  assign applied_gain = target_gain;
`endif

  // Gain is zero-extended so the multiply stays signed; +64 rounds before the /128.
  assign product = s1_data_q * $signed({1'b0, s1_gain_q});
  assign scaled  = SW'((product + $signed((SW + 9)'(64))) >>> 7);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_gain_d  = s1_gain_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    clamp_d    = clamp_q;

    if (advance) begin
      s1_valid_d = bus.s_valid;
      if (accept) begin
        s1_data_d = bus.s_data;
        s1_gain_d = applied_gain;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = scaled;
      end
    end

    if (bus.clr_flag) begin
      clamp_d = 1'b0;
    end
    if (accept && bus.env_busy && over_gmax) begin
      clamp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_gain_q  <= 8'd0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      clamp_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_gain_q  <= s1_gain_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      clamp_q    <= clamp_d;
    end
  end

  assign bus.s_ready    = advance;
  assign bus.m_valid    = s2_valid_q;
  assign bus.m_data     = s2_valid_q ? s2_data_q : '0;
  assign bus.clamp_flag = clamp_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca: inputs change and outputs are sampled on the falling edge.
module tb_envelope_vca;
  localparam int unsigned SW = 16;
  localparam int unsigned EW = 18;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  envelope_vca_if #(.SW(SW), .EW(EW)) bus ();

  envelope_vca #(.SW(SW), .EW(EW), .GMAX(127)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.env_value = '0;
    bus.env_busy  = 1'b0;
    bus.m_ready   = 1'b0;
    bus.clr_flag  = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst_b = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid);
    end
    checks++;
    if (bus.m_data !== 16'sd0) begin
      errors++; $display("FAIL reset_m_data: got %0d expected 0", bus.m_data);
    end
    checks++;
    if (bus.clamp_flag !== 1'b0) begin
      errors++; $display("FAIL reset_clamp: got %b expected 0", bus.clamp_flag);
    end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready_during: got %b expected 1", bus.s_ready);
    end
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready_after: got %b expected 1", bus.s_ready);
    end
  endtask

  task automatic test_half_gain();
    bus.env_busy  = 1'b1;
    bus.env_value = 18'd64;
    bus.s_data    = 16'sd1000;
    bus.s_valid   = 1'b1;
    bus.m_ready   = 1'b1;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL half_s_ready: got %b expected 1", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL half_latency_early: got m_valid %b expected 0", bus.m_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++; $display("FAIL half_latency: got m_valid %b expected 1", bus.m_valid);
    end
    checks++;
    if (bus.m_data !== 16'sd500) begin
      errors++; $display("FAIL half_m_data: got %0d expected 500", bus.m_data);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 16'sd0) begin
      errors++;
      $display("FAIL half_drain: got valid %b data %0d expected 0/0", bus.m_valid, bus.m_data);
    end
  endtask

  task automatic test_clamp();
    reset_dut();
    bus.env_busy  = 1'b1;
    bus.env_value = 18'd200;
    bus.s_data    = -16'sd32768;
    bus.s_valid   = 1'b1;
    bus.m_ready   = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (bus.clamp_flag !== 1'b1) begin
      errors++; $display("FAIL clamp_set: got %b expected 1", bus.clamp_flag);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== -16'sd32512) begin
      errors++;
      $display("FAIL clamp_m_data: got valid %b data %0d expected 1/-32512",
               bus.m_valid, bus.m_data);
    end
    bus.clr_flag = 1'b1;
    @(negedge clk);
    bus.clr_flag = 1'b0;
    checks++;
    if (bus.clamp_flag !== 1'b0) begin
      errors++; $display("FAIL clamp_clear: got %b expected 0", bus.clamp_flag);
    end
    bus.s_valid  = 1'b1;
    bus.clr_flag = 1'b1;
    @(negedge clk);
    bus.s_valid  = 1'b0;
    bus.clr_flag = 1'b0;
    checks++;
    if (bus.clamp_flag !== 1'b1) begin
      errors++; $display("FAIL clamp_set_wins: got %b expected 1", bus.clamp_flag);
    end
  endtask

  // Runs straight after test_clamp, so clamp_flag is already set on entry.
  task automatic test_idle_gain();
    bus.env_busy  = 1'b0;
    bus.env_value = 18'd50;
    bus.s_data    = 16'sd12345;
    bus.s_valid   = 1'b1;
    bus.m_ready   = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (bus.m_data !== -16'sd32512) begin
      errors++; $display("FAIL idle_prev_sample: got %0d expected -32512", bus.m_data);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'sd0) begin
      errors++;
      $display("FAIL idle_m_data: got valid %b data %0d expected 1/0", bus.m_valid, bus.m_data);
    end
    checks++;
    if (bus.clamp_flag !== 1'b1) begin
      errors++; $display("FAIL idle_clamp_kept: got %b expected 1", bus.clamp_flag);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] din  [4];
    logic signed [15:0] dout [4];
    logic signed [15:0] held;
    logic stalled;
    int sent;
    int rcv;
    din  = '{16'sd256, -16'sd256, 16'sd1000, 16'sd7};
    dout = '{16'sd128, -16'sd128, 16'sd500, 16'sd4};
    held = '0;
    stalled = 1'b0;
    sent = 0;
    rcv  = 0;
    reset_dut();
    for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
      bus.env_busy  = 1'b1;
      bus.env_value = 18'd64;
      bus.m_ready   = !(cyc >= 3 && cyc <= 5);
      bus.s_valid   = (sent < 4);
      bus.s_data    = (sent < 4) ? din[sent] : 16'sd0;
      #1;
      if (stalled) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== held) begin
          errors++;
          $display("FAIL b2b_hold: got valid %b data %0d expected 1/%0d",
                   bus.m_valid, bus.m_data, held);
        end
      end
      if (bus.m_valid === 1'b1 && !bus.m_ready) begin
        checks++;
        if (bus.s_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_s_ready_stall: got %b expected 0", bus.s_ready);
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready) begin
        checks++;
        if (bus.m_data !== dout[rcv]) begin
          errors++;
          $display("FAIL b2b_order: sample %0d got %0d expected %0d", rcv, bus.m_data, dout[rcv]);
        end
        rcv++;
      end
      stalled = (bus.m_valid === 1'b1) && !bus.m_ready;
      held    = bus.m_data;
      if (bus.s_valid && bus.s_ready === 1'b1) sent++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    checks++;
    if (rcv != 4) begin
      errors++; $display("FAIL b2b_count: got %0d outputs expected 4", rcv);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_no_extra: got m_valid %b expected 0", bus.m_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    bus.env_busy  = 1'b1;
    bus.env_value = 18'd200;
    bus.s_data    = 16'sd300;
    bus.s_valid   = 1'b1;
    bus.m_ready   = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'sd298 || bus.clamp_flag !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre_reset: got valid %b data %0d clamp %b expected 1/298/1",
               bus.m_valid, bus.m_data, bus.clamp_flag);
    end
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 16'sd0 || bus.clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL stall_reset: got valid %b data %0d clamp %b expected 0/0/0",
               bus.m_valid, bus.m_data, bus.clamp_flag);
    end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL stall_reset_s_ready: got %b expected 1", bus.s_ready);
    end
    bus.env_value = 18'd64;
    bus.s_data    = 16'sd1000;
    bus.s_valid   = 1'b1;
    bus.m_ready   = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL stall_post_early: got m_valid %b expected 0", bus.m_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 16'sd500) begin
      errors++;
      $display("FAIL stall_post_latency: got valid %b data %0d expected 1/500",
               bus.m_valid, bus.m_data);
    end
  endtask

  task automatic test_gain_ramp();
    int rcv;
    logic signed [15:0] exp_val;
    rcv = 0;
    reset_dut();
    bus.env_busy  = 1'b1;
    bus.env_value = 18'd10;
    bus.s_data    = 16'sd128;
    bus.m_ready   = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.s_valid = (cyc < 12);
      #1;
      if (bus.m_valid === 1'b1) begin
`ifdef ENVELOPE_VCA_SMOOTH_EN
        exp_val = (rcv < 10) ? 16'(rcv + 1) : 16'sd10;
`else
        exp_val = 16'sd10;
`endif
        checks++;
        if (bus.m_data !== exp_val) begin
          errors++;
          $display("FAIL ramp_sample: index %0d got %0d expected %0d", rcv, bus.m_data, exp_val);
        end
        rcv++;
      end
      @(negedge clk);
    end
    checks++;
    if (rcv != 12) begin
      errors++; $display("FAIL ramp_count: got %0d outputs expected 12", rcv);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_half_gain();
    test_clamp();
    test_idle_gain();
    test_back_to_back();
    test_reset_mid_stall();
    test_gain_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/envelope_vca.md
ENVELOPE_VCA -- requirements
Module: envelope_vca

Interface
REQ-001 Parameter SW, default 16, SHALL set the signed audio sample width.
REQ-002 Parameter EW, default 18, SHALL set the unsigned envelope value width.
REQ-003 Parameter GMAX, default 127, SHALL set the maximum gain code (unity = 128, never reached).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_b, input, 1, SHALL be the reset, synchronous and active-low.
REQ-006 Port s_data, input, SW, SHALL carry the signed oscillator sample.
REQ-007 Port s_valid, input, 1, SHALL mark s_data valid.
REQ-008 Port s_ready, output, 1, SHALL indicate the block accepts s_data this cycle.
REQ-009 Port env_value, input, EW, SHALL carry the envelope generator out_value.
REQ-010 Port env_busy, input, 1, SHALL carry the envelope generator busy flag.
REQ-011 Port m_data, output, SW, SHALL carry the signed scaled sample.
REQ-012 Port m_valid, output, 1, SHALL mark m_data valid.
REQ-013 Port m_ready, input, 1, SHALL indicate the downstream consumer accepts m_data.
REQ-014 Port clamp_flag, output, 1, SHALL be a sticky flag for envelope values above GMAX.
REQ-015 Port clr_flag, input, 1, SHALL clear clamp_flag.

Function
REQ-016 Accept SHALL occur on a cycle with s_valid=1 and s_ready=1; transfer out on m_valid=1 and m_ready=1.
REQ-017 Pipeline SHALL be two register stages (S1: sample+gain; S2: product result); latency 2 cycles from accept to m_valid with m_ready held high; throughput one sample/cycle.
REQ-018 advance = !S2_valid || m_ready; s_ready SHALL equal advance (combinational, no dependence on s_valid).
REQ-019 When advance=0, S1 and S2 contents and m_valid/m_data SHALL hold unchanged.
REQ-020 Target gain SHALL be sampled only at accept: env_busy=0 -> 0; else min(env_value, GMAX) as 8-bit unsigned.
REQ-021 Accept with env_busy=1 and env_value>GMAX SHALL set clamp_flag next cycle.
REQ-022 clr_flag=1 SHALL clear clamp_flag next cycle; simultaneous set and clear -> set wins.
REQ-023 Product SHALL be full-precision signed SW+9 bits: s_data * {0,gain}; result = (product + 64) >>> 7 (arithmetic), truncated to SW bits; no overflow possible since gain <= 127.
REQ-024 m_data SHALL show 0 whenever m_valid=0.
REQ-025 env_value/env_busy changes while stalled SHALL NOT affect already-accepted samples.

Reset
REQ-026 rst_b=0 at a rising edge SHALL clear S1/S2 valid, m_valid=0, m_data=0, clamp_flag=0, internal gain=0; in-flight samples discarded.
REQ-027 s_ready SHALL read 1 during and immediately after reset (pipeline empty).
REQ-028 Reset mid-stall SHALL drop the held output; first post-reset accept sees 2-cycle latency.

Configuration
REQ-029 Macro ENVELOPE_VCA_SMOOTH_EN defined: applied gain register SHALL step toward target by at most +/-1 per accept (zipper-noise suppression), reset value 0.
REQ-030 Macro undefined: applied gain SHALL equal target gain at each accept; no smoothing register behaviour.

Verification
REQ-031 env_busy=1, env_value=64, s_data=1000, m_ready=1 -> m_data=500, m_valid exactly 2 cycles after accept.
REQ-032 env_busy=1, env_value=200, s_data=-32768 -> m_data=-32512, clamp_flag=1; clr_flag pulse -> clamp_flag=0.
REQ-033 env_busy=0, env_value=50, s_data=12345 -> m_data=0, clamp_flag unchanged.
REQ-034 Stream 4 samples, m_ready low 3 cycles mid-stream -> s_ready low while S2 full, no sample lost/duplicated, order preserved.
REQ-035 rst_b low one cycle while m_valid=1 stalled -> m_valid=0, m_data=0, clamp_flag=0 next cycle.
REQ-036 With ENVELOPE_VCA_SMOOTH_EN: gain target 0 -> 10, s_data=128 repeated -> m_data 1,2,...,10 then steady 10.
